// File: rtl/stream_checker_pkg.sv
// Shared definitions for the stream checker: event codes and FSM states.
// No logic; constants only.
// Imported by stream_checker.
package stream_checker_pkg;

    // Event classification carried on evt_code.
    localparam logic [2:0] EVT_MATCH         = 3'd0;
    localparam logic [2:0] EVT_MISMATCH      = 3'd1;
    localparam logic [2:0] EVT_UNEXPECTED    = 3'd2;
    localparam logic [2:0] EVT_TIMEOUT       = 3'd3;
    localparam logic [2:0] EVT_FLUSH_PENDING = 3'd4;

    // IDLE: expected queue empty, watchdog parked.
    // WAIT: at least one expectation outstanding, watchdog running.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: generic synchronous FIFO with registered status flags and occupancy.
// Latency: a pushed entry becomes visible at the head one cycle after the push.
// Backpressure: push_rdy is a register (not full); a pop at full raises it next cycle.
//
// Ports:
//   clk, srst_n        clock, synchronous active-low reset
//   clr                synchronous clear; drops contents and wins over push/pop
//   push, push_data    write request (accepted only while push_rdy=1)
//   push_rdy           registered not-full
//   pop                read request (ignored while empty)
//   head_data          oldest entry (valid while empty=0)
//   empty, count       registered status
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_rdy,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int              PW       = DEPTH_LOG2 + 1;
    localparam int              DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0]   FULL_CNT = PW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // One extra pointer bit distinguishes full from empty.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] rd_nxt;
    logic [PW-1:0] cnt_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push   = push & push_rdy & ~clr;
    assign do_pop    = pop & ~empty & ~clr;
    assign head_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_comb begin
        wr_nxt  = wr_ptr + PW'(do_push);
        rd_nxt  = rd_ptr + PW'(do_pop);
        cnt_nxt = wr_nxt - rd_nxt;
    end

    // Flags are computed from the next pointers so they are plain registers
    // and never lag the pointers.
    always_ff @(posedge clk) begin
        if (!srst_n || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            empty    <= 1'b1;
            push_rdy <= 1'b1;
            count    <= '0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            empty    <= (cnt_nxt == '0);
            push_rdy <= (cnt_nxt != FULL_CNT);
            count    <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_n && do_push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/stream_checker.sv
// Purpose: in-order scoreboard comparing queued expected beats against actual beats, with stall watchdog.
// Latency: one classified event registered one cycle after the act beat, timeout or flush causing it.
// Backpressure: never stalls the DUT (act_ready=1); exp_ready is registered not-full of the expected queue.
//
// Ports:
//   clk, srst_n                       clock, synchronous active-low reset
//   exp_valid/exp_ready/exp_data      expected-beat stream into the queue
//   act_valid/act_ready/act_data      actual-beat stream from the DUT
//   flush                             drop all expectations, clear watchdog
//   evt_valid/evt_code/evt_exp/evt_act  one-cycle classified event
//   nb_match/nb_mismatch/nb_unexpected  saturating counters
//   timed_out                         sticky timeout flag
//   pending                           queued expected entries
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       srst_n,
    input  logic                       exp_valid,
    output logic                       exp_ready,
    input  logic [DATA_WIDTH-1:0]      exp_data,
    input  logic                       act_valid,
    output logic                       act_ready,
    input  logic [DATA_WIDTH-1:0]      act_data,
    input  logic                       flush,
    output logic                       evt_valid,
    output logic [2:0]                 evt_code,
    output logic [DATA_WIDTH-1:0]      evt_exp,
    output logic [DATA_WIDTH-1:0]      evt_act,
    output logic [CNT_WIDTH-1:0]       nb_match,
    output logic [CNT_WIDTH-1:0]       nb_mismatch,
    output logic [CNT_WIDTH-1:0]       nb_unexpected,
    output logic                       timed_out,
    output logic [FIFO_DEPTH_LOG2:0]   pending
);

    localparam int                   PW      = FIFO_DEPTH_LOG2 + 1;
    localparam int                   WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0]        ONE     = PW'(1);

    logic                  q_empty;
    logic [DATA_WIDTH-1:0] q_head;
    logic                  push_acc;
    logic                  pop_acc;
    logic                  nonempty_nxt;

    state_t                state;
    logic [WD_W-1:0]       wd;

    assign act_ready = 1'b1;

    // Flush drops both the push and the act beat of its cycle.
    assign push_acc = exp_valid & exp_ready & ~flush;
    assign pop_acc  = act_valid & ~q_empty & ~flush;

    // Queue occupancy after this edge; keeps the FSM state aligned with the
    // queue's registered empty flag so WAIT means "entry visible".
    assign nonempty_nxt = push_acc | ((pending != '0) & ~((pending == ONE) & pop_acc));

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_exp_q (
        .clk       (clk),
        .srst_n    (srst_n),
        .clr       (flush),
        .push      (exp_valid),
        .push_data (exp_data),
        .push_rdy  (exp_ready),
        .pop       (act_valid),
        .head_data (q_head),
        .empty     (q_empty),
        .count     (pending)
    );

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state         <= ST_IDLE;
            wd            <= '0;
            evt_valid     <= 1'b0;
            evt_code      <= EVT_MATCH;
            evt_exp       <= '0;
            evt_act       <= '0;
            nb_match      <= '0;
            nb_mismatch   <= '0;
            nb_unexpected <= '0;
            timed_out     <= 1'b0;
        end else begin
            // Event fields read as zero whenever no event is flagged.
            evt_valid <= 1'b0;
            evt_code  <= EVT_MATCH;
            evt_exp   <= '0;
            evt_act   <= '0;

            if (flush) begin
                if (!q_empty) begin
                    evt_valid <= 1'b1;
                    evt_code  <= EVT_FLUSH_PENDING;
                    evt_exp   <= q_head;
                end
                wd    <= '0;
                state <= ST_IDLE;
            end else begin
                if (act_valid) begin
                    // An act beat always restarts the watchdog, so it can
                    // never coincide with a timeout.
                    wd        <= '0;
                    evt_valid <= 1'b1;
                    evt_act   <= act_data;
                    if (!q_empty) begin
                        evt_exp <= q_head;
                        if (q_head == act_data) begin
                            evt_code <= EVT_MATCH;
                            if (nb_match != CNT_MAX) nb_match <= nb_match + 1'b1;
                        end else begin
                            evt_code <= EVT_MISMATCH;
                            if (nb_mismatch != CNT_MAX) nb_mismatch <= nb_mismatch + 1'b1;
                        end
                    end else begin
                        evt_code <= EVT_UNEXPECTED;
                        if (nb_unexpected != CNT_MAX) nb_unexpected <= nb_unexpected + 1'b1;
                    end
                end else if (state == ST_WAIT) begin
                    if (wd == WD_LAST) begin
                        evt_valid <= 1'b1;
                        evt_code  <= EVT_TIMEOUT;
                        timed_out <= 1'b1;
                        wd        <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end else begin
                    wd <= '0;
                end

                state <= nonempty_nxt ? ST_WAIT : ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
module tb_stream_checker;

    localparam int DW    = 32;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic          clk = 1'b0;
    logic          srst_n;
    logic          exp_valid;
    logic          exp_ready;
    logic [DW-1:0] exp_data;
    logic          act_valid;
    logic          act_ready;
    logic [DW-1:0] act_data;
    logic          flush;
    logic          evt_valid;
    logic [2:0]    evt_code;
    logic [DW-1:0] evt_exp;
    logic [DW-1:0] evt_act;
    logic [CW-1:0] nb_match;
    logic [CW-1:0] nb_mismatch;
    logic [CW-1:0] nb_unexpected;
    logic          timed_out;
    logic [DL2:0]  pending;

    stream_checker #(
        .DATA_WIDTH      (DW),
        .FIFO_DEPTH_LOG2 (DL2),
        .TIMEOUT_CYCLES  (TO),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk           (clk),
        .srst_n        (srst_n),
        .exp_valid     (exp_valid),
        .exp_ready     (exp_ready),
        .exp_data      (exp_data),
        .act_valid     (act_valid),
        .act_ready     (act_ready),
        .act_data      (act_data),
        .flush         (flush),
        .evt_valid     (evt_valid),
        .evt_code      (evt_code),
        .evt_exp       (evt_exp),
        .evt_act       (evt_act),
        .nb_match      (nb_match),
        .nb_mismatch   (nb_mismatch),
        .nb_unexpected (nb_unexpected),
        .timed_out     (timed_out),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of outstanding expectations plus a stall count.
    logic [DW-1:0] q[$];
    int            stall;
    int            m_match, m_mism, m_unexp;
    bit            m_to;
    bit            m_ev;
    logic [2:0]    m_code;
    logic [DW-1:0] m_exp, m_act;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic cyc(input bit ev, input logic [DW-1:0] ed, input bit av,
                       input logic [DW-1:0] ad, input bit fl, input bit rst);
        logic [DW-1:0] h;
        bit            rdy;
        exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad;
        flush = fl; srst_n = !rst;
        m_ev = 0; m_code = 3'd0; m_exp = '0; m_act = '0;
        if (rst) begin
            q.delete(); stall = 0; m_match = 0; m_mism = 0; m_unexp = 0; m_to = 0;
        end else begin
            rdy = (q.size() < DEPTH);
            if (fl) begin
                if (q.size() != 0) begin m_ev = 1; m_code = 3'd4; m_exp = q[0]; end
                q.delete(); stall = 0;
            end else begin
                if (av) begin
                    stall = 0; m_ev = 1; m_act = ad;
                    if (q.size() != 0) begin
                        h = q.pop_front(); m_exp = h;
                        if (h == ad) begin m_code = 3'd0; m_match = sat(m_match + 1); end
                        else begin m_code = 3'd1; m_mism = sat(m_mism + 1); end
                    end else begin
                        m_code = 3'd2; m_unexp = sat(m_unexp + 1);
                    end
                end else if (q.size() != 0) begin
                    if (stall == TO - 1) begin m_ev = 1; m_code = 3'd3; m_to = 1; stall = 0; end
                    else stall++;
                end else begin
                    stall = 0;
                end
                if (ev && rdy) q.push_back(ed);
            end
        end
        @(posedge clk); #1;
        chk("model_evt", {evt_valid, evt_code, evt_exp, evt_act}, {m_ev, m_code, m_exp, m_act});
        chk("model_status",
            {act_ready, exp_ready, pending, nb_match, nb_mismatch, nb_unexpected, timed_out},
            {1'b1, (q.size() < DEPTH) ? 1'b1 : 1'b0, 3'(q.size()), 4'(m_match), 4'(m_mism), 4'(m_unexp), m_to});
    endtask

    task automatic idle();
        cyc(0, '0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, '0, 0, '0, 0, 1);
    endtask

    typedef struct {
        bit            ev;
        logic [DW-1:0] ed;
        bit            av;
        logic [DW-1:0] ad;
        bit            fl;
        bit            e_vld;
        logic [2:0]    e_code;
        logic [DW-1:0] e_exp;
        logic [DW-1:0] e_act;
        int            e_pend;
    } vec_t;

    vec_t tbl[11];

    initial begin
        srst_n = 0; exp_valid = 0; exp_data = '0; act_valid = 0; act_data = '0; flush = 0;

        tbl[0]  = '{1, 32'h11, 0, 32'h0,  0, 0, 3'd0, 32'h0,  32'h0,  1};
        tbl[1]  = '{1, 32'h22, 0, 32'h0,  0, 0, 3'd0, 32'h0,  32'h0,  2};
        tbl[2]  = '{1, 32'h33, 0, 32'h0,  0, 0, 3'd0, 32'h0,  32'h0,  3};
        tbl[3]  = '{0, 32'h0,  1, 32'h11, 0, 1, 3'd0, 32'h11, 32'h11, 2};
        tbl[4]  = '{0, 32'h0,  1, 32'h22, 0, 1, 3'd0, 32'h22, 32'h22, 1};
        tbl[5]  = '{0, 32'h0,  1, 32'h33, 0, 1, 3'd0, 32'h33, 32'h33, 0};
        tbl[6]  = '{1, 32'hA5, 0, 32'h0,  0, 0, 3'd0, 32'h0,  32'h0,  1};
        tbl[7]  = '{0, 32'h0,  1, 32'h5A, 0, 1, 3'd1, 32'hA5, 32'h5A, 0};
        tbl[8]  = '{1, 32'h77, 1, 32'h77, 0, 1, 3'd2, 32'h0,  32'h77, 1};
        tbl[9]  = '{0, 32'h0,  0, 32'h0,  1, 1, 3'd4, 32'h77, 32'h0,  0};
        tbl[10] = '{0, 32'h0,  0, 32'h0,  0, 0, 3'd0, 32'h0,  32'h0,  0};

        // Reset state.
        do_reset(); do_reset();
        chk("reset_evt", {evt_valid, evt_code, evt_exp, evt_act}, '0);
        chk("reset_status", {exp_ready, act_ready, pending, nb_match, nb_mismatch, nb_unexpected, timed_out},
            {1'b1, 1'b1, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0});

        // Directed vectors: match run, mismatch, unexpected-without-bypass, flush.
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].ev, tbl[i].ed, tbl[i].av, tbl[i].ad, tbl[i].fl, 0);
            chk($sformatf("vec%0d_evt", i), {evt_valid, evt_code, evt_exp, evt_act},
                {tbl[i].e_vld, tbl[i].e_code, tbl[i].e_exp, tbl[i].e_act});
            chk($sformatf("vec%0d_pending", i), pending, 3'(tbl[i].e_pend));
            if (i == 5) chk("nb_match_after_3", nb_match, 4'd3);
        end
        chk("vec_counters", {nb_match, nb_mismatch, nb_unexpected}, {4'd3, 4'd1, 4'd1});

        // Watchdog: timeout 8 cycles after the entry is visible, then again 8 later.
        do_reset();
        cyc(1, 32'hC0, 0, '0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            idle();
            chk($sformatf("timeout_at_%0d", i), {evt_valid, evt_valid && evt_code == 3'd3},
                {(i == 8 || i == 16) ? 2'b11 : 2'b00});
        end
        chk("timed_out_sticky", timed_out, 1'b1);

        // Full queue: 4 accepted, exp_ready low, rises the cycle after a pop.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 32'h100 + i, 0, '0, 0, 0);
            chk($sformatf("full_rdy_%0d", i), {exp_ready, pending}, {(i < 4) ? 1'b1 : 1'b0, 3'(i > 4 ? 4 : i)});
        end
        cyc(1, 32'h200, 1, 32'h101, 0, 0);
        chk("full_pop_rdy", {exp_ready, pending, evt_valid, evt_code}, {1'b1, 3'd3, 1'b1, 3'd0});
        for (int i = 2; i <= 4; i++) cyc(0, '0, 1, 32'h100 + i, 0, 0);
        chk("full_fifth_dropped", {pending, nb_match}, {3'd0, 4'd4});

        // Flush with act beat: one FLUSH_PENDING, act beat dropped.
        do_reset();
        cyc(1, 32'hC1, 0, '0, 0, 0);
        cyc(1, 32'hC2, 0, '0, 0, 0);
        cyc(1, 32'hC3, 0, '0, 0, 0);
        cyc(1, 32'hC4, 1, 32'hC1, 1, 0);
        chk("flush_evt", {evt_valid, evt_code, evt_exp, evt_act}, {1'b1, 3'd4, 32'hC1, 32'h0});
        chk("flush_status", {pending, nb_match, nb_mismatch, nb_unexpected}, {3'd0, 12'd0});
        idle();
        chk("flush_no_second_evt", evt_valid, 1'b0);

        // Reset mid-stream.
        do_reset();
        cyc(1, 32'hAA, 0, '0, 0, 0);
        cyc(1, 32'hBB, 1, 32'hAA, 0, 0);
        cyc(0, '0, 1, 32'hBB, 0, 1);
        chk("midreset_outputs",
            {evt_valid, evt_code, evt_exp, evt_act, exp_ready, pending, nb_match, nb_mismatch, nb_unexpected, timed_out},
            {1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0});
        idle();
        chk("midreset_after", {evt_valid, pending}, {1'b0, 3'd0});

        // Saturation of nb_match at all-ones.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 32'h300 + i, 0, '0, 0, 0);
            cyc(0, '0, 1, 32'h300 + i, 0, 0);
            chk($sformatf("sat_%0d", i), {evt_valid, evt_code, nb_match}, {1'b1, 3'd0, 4'(sat(i + 1))});
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int act_pct;
            act_pct = ((n / 300) % 2 == 0) ? 35 : 8;
            cyc($urandom_range(0, 99) < 50, 32'($urandom_range(0, 3)),
                $urandom_range(0, 99) < act_pct, 32'($urandom_range(0, 3)),
                $urandom_range(0, 99) < 2, $urandom_range(0, 999) < 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
